// File: rtl/bhp_port_scheduler.sv
// Port scheduler for the branch history predictor counter table.
// The table has a single port. Decode-stage lookups always get it first.
// Mem-stage outcome updates wait in a small FIFO and are applied as
// read-modify-write sequences in cycles the port is free. After reset the
// table is swept to INIT_VAL.
module bhp_port_scheduler #(
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned BUF_DEPTH = 4,
    parameter logic [1:0]  INIT_VAL  = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_addr,
    input  logic [31:0]      lookup_offset,
    output logic             pred_valid,
    output logic             prediction,
    output logic [1:0]       pred_counter,
    input  logic             upd_valid,
    input  logic [31:0]      upd_addr,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             upd_drop,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             init_done,
    output logic             busy
);

    localparam int unsigned       PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(BUF_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT    = 2'b00,
        ST_IDLE    = 2'b01,
        ST_RD_WAIT = 2'b10,
        ST_WR      = 2'b11
    } state_t;

    // 2-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (cnt == 2'b11) begin
                res = 2'b11;
            end else begin
                res = cnt + 2'b01;
            end
        end else begin
            if (cnt == 2'b00) begin
                res = 2'b00;
            end else begin
                res = cnt - 2'b01;
            end
        end
        return res;
    endfunction

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    state_t                r_state;
    logic                  r_started;
    logic [IDX_W-1:0]      r_init_ptr;
    logic                  r_init_done;

    logic [IDX_W-1:0]      r_fifo_idx [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  r_fifo_taken;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W:0]        r_count;

    logic [1:0]            r_wr_val;
    logic                  r_pred_valid;
    logic                  r_pred_use_reg;
    logic [1:0]            r_pred_reg_val;
    logic [1:0]            r_pred_hold;
    logic                  r_drop;

    // ---------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------
    state_t                w_state_next;
    logic [31:0]           w_lk_sum;
    logic [IDX_W-1:0]      w_lk_idx;
    logic [IDX_W-1:0]      w_upd_idx;
    logic [IDX_W-1:0]      w_head_idx;
    logic                  w_head_taken;
    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tbl_en;
    logic                  w_tbl_we;
    logic [IDX_W-1:0]      w_tbl_addr;
    logic [1:0]            w_tbl_wdata;
    logic                  w_byp_hit;
    logic [1:0]            w_byp_val;
    logic [1:0]            w_pred_counter;
    logic                  w_unused_bits;

    assign w_lk_sum      = lookup_addr + lookup_offset;
    assign w_lk_idx      = w_lk_sum[IDX_W+1:2];
    assign w_upd_idx     = upd_addr[IDX_W+1:2];
    assign w_head_idx    = r_fifo_idx[r_rd_ptr];
    assign w_head_taken  = r_fifo_taken[r_rd_ptr];
    // Ready comes from the registered count only, so a slot freed this
    // cycle is not reusable until the next one.
    assign w_ready       = (r_count != FULL_CNT);
    assign w_push        = upd_valid && w_ready;
    assign w_unused_bits = ^{w_lk_sum[31:IDX_W+2], w_lk_sum[1:0],
                             upd_addr[31:IDX_W+2], upd_addr[1:0]};

    // Next-state and table port arbitration: lookups first, then INIT
    // sweep or the update RMW sequence.
    always_comb begin
        w_state_next = r_state;
        w_tbl_en     = 1'b0;
        w_tbl_we     = 1'b0;
        w_tbl_addr   = '0;
        w_tbl_wdata  = 2'b00;
        w_pop        = 1'b0;
        case (r_state)
            ST_INIT: begin
                // Lookups during the sweep are answered with INIT_VAL
                // without touching the port.
                if (r_started) begin
                    w_tbl_en    = 1'b1;
                    w_tbl_we    = 1'b1;
                    w_tbl_addr  = r_init_ptr;
                    w_tbl_wdata = INIT_VAL;
                    if (r_init_ptr == LAST_IDX) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_INIT;
                    end
                end else begin
                    w_state_next = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (lookup_valid) begin
                    w_tbl_en   = 1'b1;
                    w_tbl_addr = w_lk_idx;
                end else if (r_count != '0) begin
                    w_tbl_en     = 1'b1;
                    w_tbl_addr   = w_head_idx;
                    w_state_next = ST_RD_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // Read data for the head entry arrives now; the port is
                // free for a lookup this cycle.
                w_state_next = ST_WR;
                if (lookup_valid) begin
                    w_tbl_en   = 1'b1;
                    w_tbl_addr = w_lk_idx;
                end else begin
                    w_tbl_en = 1'b0;
                end
            end
            ST_WR: begin
                if (lookup_valid) begin
                    w_tbl_en     = 1'b1;
                    w_tbl_addr   = w_lk_idx;
                    w_state_next = ST_WR;
                end else begin
                    w_tbl_en     = 1'b1;
                    w_tbl_we     = 1'b1;
                    w_tbl_addr   = w_head_idx;
                    w_tbl_wdata  = r_wr_val;
                    w_pop        = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // Bypass source for a lookup issued this cycle: INIT_VAL during the
    // sweep, or the in-flight RMW value when the lookup hits the head index.
    always_comb begin
        w_byp_hit = 1'b0;
        w_byp_val = 2'b00;
        case (r_state)
            ST_INIT: begin
                w_byp_hit = 1'b1;
                w_byp_val = INIT_VAL;
            end
            ST_RD_WAIT: begin
                w_byp_hit = (w_lk_idx == w_head_idx);
                w_byp_val = sat_step(tbl_rdata, w_head_taken);
            end
            ST_WR: begin
                w_byp_hit = (w_lk_idx == w_head_idx);
                w_byp_val = r_wr_val;
            end
            default: begin
                w_byp_hit = 1'b0;
                w_byp_val = 2'b00;
            end
        endcase
    end

    // Prediction output select: live result after a lookup, else held value.
    always_comb begin
        if (r_pred_valid) begin
            if (r_pred_use_reg) begin
                w_pred_counter = r_pred_reg_val;
            end else begin
                w_pred_counter = tbl_rdata;
            end
        end else begin
            w_pred_counter = r_pred_hold;
        end
    end

    // FSM state, init sweep pointer and init_done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_started   <= 1'b0;
            r_init_ptr  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_started <= 1'b1;
            if ((r_state == ST_INIT) && r_started) begin
                r_init_ptr <= r_init_ptr + IDX_ONE;
                if (r_init_ptr == LAST_IDX) begin
                    r_init_done <= 1'b1;
                end
            end
        end
    end

    // Pending-update FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_fifo_idx[i] <= '0;
            end
            r_fifo_taken <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (w_push) begin
                r_fifo_idx[r_wr_ptr]   <= w_upd_idx;
                r_fifo_taken[r_wr_ptr] <= upd_taken;
                r_wr_ptr               <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // RMW write value, latched while the head read data is on tbl_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_val <= 2'b00;
        end else if (r_state == ST_RD_WAIT) begin
            r_wr_val <= sat_step(tbl_rdata, w_head_taken);
        end
    end

    // Prediction pipeline: valid flag, bypass capture and output hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid   <= 1'b0;
            r_pred_use_reg <= 1'b0;
            r_pred_reg_val <= 2'b00;
            r_pred_hold    <= 2'b00;
        end else begin
            r_pred_valid <= lookup_valid;
            if (r_pred_valid) begin
                r_pred_hold <= w_pred_counter;
            end
            if (lookup_valid) begin
                r_pred_use_reg <= w_byp_hit;
                r_pred_reg_val <= w_byp_val;
            end
        end
    end

    // One-cycle drop pulse for an update offered while the FIFO is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= upd_valid && !w_ready;
        end
    end

    assign tbl_en       = w_tbl_en;
    assign tbl_we       = w_tbl_we;
    assign tbl_addr     = w_tbl_addr;
    assign tbl_wdata    = w_tbl_wdata;
    assign pred_valid   = r_pred_valid;
    assign pred_counter = w_pred_counter;
    assign prediction   = w_pred_counter[1];
    assign upd_ready    = w_ready;
    assign upd_drop     = r_drop;
    assign init_done    = r_init_done;
    assign busy         = (r_count != '0) || (r_state == ST_RD_WAIT) || (r_state == ST_WR);

endmodule

// File: tb/tb_bhp_port_scheduler.sv
// Scoreboard bench for bhp_port_scheduler: a behavioural counter table
// answers the port, and expected predictions / table writes are queued at
// stimulus time and compared when the DUT produces them.
module tb_bhp_port_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_addr;
    logic [31:0] lookup_offset;
    logic        pred_valid;
    logic        prediction;
    logic [1:0]  pred_counter;
    logic        upd_valid;
    logic [31:0] upd_addr;
    logic        upd_taken;
    logic        upd_ready;
    logic        upd_drop;
    logic        tbl_en;
    logic        tbl_we;
    logic [5:0]  tbl_addr;
    logic [1:0]  tbl_wdata;
    logic [1:0]  tbl_rdata;
    logic        init_done;
    logic        busy;

    typedef struct {
        logic [5:0] idx;
        logic [1:0] val;
    } wr_t;

    logic [1:0] mem [64];
    logic [1:0] ref_tbl [64];
    logic [1:0] pq [$];
    wr_t        wq [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         wr_count = 0;
    logic       we_seen  = 1'b0;

    always #5 clk = ~clk;

    bhp_port_scheduler #(.IDX_W(6), .BUF_DEPTH(4), .INIT_VAL(2'b01)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_offset(lookup_offset),
        .pred_valid(pred_valid), .prediction(prediction), .pred_counter(pred_counter),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .upd_drop(upd_drop),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .tbl_rdata(tbl_rdata), .init_done(init_done), .busy(busy)
    );

    // Behavioural single-port table with registered read data.
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= mem[tbl_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_step(input logic [1:0] c, input logic t);
        case ({t, c})
            3'b100: return 2'b01;
            3'b101: return 2'b10;
            3'b110: return 2'b11;
            3'b111: return 2'b11;
            3'b000: return 2'b00;
            3'b001: return 2'b00;
            3'b010: return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Output monitor: pops predictions and post-init table writes.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pred_valid) begin
                if (pq.size() == 0) begin
                    chk("pred_unexpected", pred_valid, 1'b0);
                end else begin
                    logic [1:0] e;
                    e = pq.pop_front();
                    chk("pred_counter", pred_counter, e);
                    chk("prediction", prediction, e[1]);
                end
            end
            if (init_done && tbl_en && tbl_we) begin
                wr_count++;
                if (wq.size() == 0) begin
                    chk("wr_unexpected", tbl_we, 1'b0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", tbl_addr, w.idx);
                    chk("wr_data", tbl_wdata, w.val);
                end
            end
        end
    end

    // One cycle of stimulus; inputs change just after the rising edge.
    task automatic cyc(input logic lk, input logic [31:0] la, input logic [31:0] lo,
                       input logic up, input logic [31:0] ua, input logic ut, input logic acc);
        logic [31:0] s;
        logic [5:0]  li;
        logic [5:0]  ui;
        wr_t         w;
        lookup_valid  = lk;
        lookup_addr   = la;
        lookup_offset = lo;
        upd_valid     = up;
        upd_addr      = ua;
        upd_taken     = ut;
        if (lk) begin
            s  = la + lo;
            li = s[7:2];
            pq.push_back(ref_tbl[li]);
        end
        if (up) begin
            chk("upd_ready", upd_ready, acc);
            if (acc) begin
                ui          = ua[7:2];
                ref_tbl[ui] = exp_step(ref_tbl[ui], ut);
                w.idx       = ui;
                w.val       = ref_tbl[ui];
                wq.push_back(w);
            end
        end
        @(negedge clk);
        if (tbl_we) we_seen = 1'b1;
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && wq.size() != 0; i++) idle();
        chk("drain_timeout", wq.size(), 0);
    endtask

    task automatic init_check();
        int   n;
        logic done_seen;
        n = 0;
        done_seen = 1'b0;
        for (int it = 0; it < 80 && !done_seen; it++) begin
            lookup_valid = (it == 2);
            if (it == 2) begin
                lookup_addr   = 32'h40;
                lookup_offset = 32'h0;
                pq.push_back(2'b01);
            end
            @(negedge clk);
            if (tbl_en) begin
                chk("init_we", tbl_we, 1'b1);
                chk("init_addr", tbl_addr, n);
                chk("init_wdata", tbl_wdata, 2'b01);
                chk("init_done_early", init_done, 1'b0);
                n++;
                if (n == 64) begin
                    @(negedge clk);
                    chk("init_done_rise", init_done, 1'b1);
                    chk("post_init_idle", tbl_en, 1'b0);
                    done_seen = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        lookup_valid = 1'b0;
        chk("init_writes", n, 64);
    endtask

    task automatic do_reset();
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        rst_n        = 1'b0;
        pq.delete();
        wq.delete();
        for (int i = 0; i < 64; i++) ref_tbl[i] = 2'b01;
        #1;
        chk("rst_tbl_en", tbl_en, 1'b0);
        chk("rst_tbl_we", tbl_we, 1'b0);
        chk("rst_tbl_addr", tbl_addr, 6'd0);
        chk("rst_tbl_wdata", tbl_wdata, 2'b00);
        chk("rst_pred_valid", pred_valid, 1'b0);
        chk("rst_pred_counter", pred_counter, 2'b00);
        chk("rst_prediction", prediction, 1'b0);
        chk("rst_upd_drop", upd_drop, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_upd_ready", upd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init_check();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        lookup_valid  = 1'b0;
        lookup_addr   = 32'h0;
        lookup_offset = 32'h0;
        upd_valid     = 1'b0;
        upd_addr      = 32'h0;
        upd_taken     = 1'b0;
        rst_n         = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 2'b11;
        do_reset();

        // Three taken updates to index 1, then lookup.
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b1, 1'b1);
        drain();
        cyc(1'b1, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();

        // Three not-taken updates; prediction output must hold meanwhile.
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0, 1'b1);
        drain();
        chk("pred_hold", pred_counter, 2'b11);
        chk("pred_valid_low", pred_valid, 1'b0);
        cyc(1'b1, 32'h0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();

        // Update starved by 10 cycles of lookups.
        we_seen = 1'b0;
        cyc(1'b1, 32'h100, 32'h0, 1'b1, 32'hC, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("no_we_during_lookup", we_seen, 1'b0);
        chk("busy_pending", busy, 1'b1);
        w0 = wr_count;
        for (int i = 0; i < 3 && wr_count == w0; i++) idle();
        chk("wr_within_3", wr_count, w0 + 1);
        chk("busy_after_write", busy, 1'b0);

        // FIFO fill under lookups; fifth update dropped.
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h100, 32'h0, 1'b1, 32'h10 + 32'(4 * i), i[0], (i < 4));
        chk("upd_drop_pulse", upd_drop, 1'b1);
        cyc(1'b1, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("upd_drop_single", upd_drop, 1'b0);
        w0 = wr_count;
        drain();
        chk("fifo_write_count", wr_count - w0, 4);
        chk("pq_empty_mid", pq.size(), 0);

        // Bypass of the in-flight RMW value, then reset mid-RMW.
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b1);
        idle();
        we_seen = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("no_we_bypass_hold", we_seen, 1'b0);
        do_reset();
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b1);
        drain();
        cyc(1'b1, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        idle();

        chk("pq_empty_end", pq.size(), 0);
        chk("wq_empty_end", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bhp_port_scheduler.md
Name: bhp_port_scheduler

Overview:
Shares the single-ported 2-bit saturating-counter table of the branch history predictor between two requesters. The decode-stage requester issues prediction lookups; the memory-stage requester issues outcome updates. Lookups always win the port. Updates are buffered and applied as read-modify-write (RMW) sequences in cycles the port is free. After reset the block sweeps the table to a known counter value.

Parameters:
IDX_W, 6, table index width (2^IDX_W entries)
BUF_DEPTH, 4, pending-update FIFO depth (power of 2, >=2)
INIT_VAL, 2'b01, counter value written to every entry during init (weakly not-taken)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
lookup_valid  in  1  decode-stage branch lookup request (branch_decode_sig)
lookup_addr  in  32  branch PC
lookup_offset  in  32  added to lookup_addr before indexing
pred_valid  out  1  prediction result valid
prediction  out  1  predicted taken (= pred_counter[1])
pred_counter  out  2  counter value returned for lookup
upd_valid  in  1  mem-stage resolved branch (branch_mem_sig)
upd_addr  in  32  PC of resolved branch
upd_taken  in  1  actual branch decision
upd_ready  out  1  FIFO not full
upd_drop  out  1  1-cycle pulse: upd_valid seen while FIFO full
tbl_en  out  1  table port enable
tbl_we  out  1  table write enable
tbl_addr  out  IDX_W  table index
tbl_wdata  out  2  table write data
tbl_rdata  in  2  table read data, valid the cycle after a tbl_en && !tbl_we access
init_done  out  1  high once init sweep is complete
busy  out  1  FIFO non-empty or FSM not IDLE/INIT

Behaviour:
- Indexing: lookup index = (lookup_addr + lookup_offset)[IDX_W+1:2], 32-bit wrap-around add. Update index = upd_addr[IDX_W+1:2].
- Reset (async, rst_n low):
  - FSM goes to INIT. FIFO is emptied. Init pointer is 0.
  - Outputs: tbl_en/tbl_we/pred_valid/prediction/upd_drop/init_done = 0; pred_counter = 0; tbl_addr = 0; tbl_wdata = 0.
  - upd_ready = 1 (FIFO empty); busy = 0.
  - A reset mid-RMW abandons the write and discards all buffered updates.
- FSM states:
  - INIT:
    - Each cycle writes INIT_VAL to the entry at the init pointer and increments the pointer.
    - After entry 2^IDX_W-1 is written, goes to IDLE and sets init_done the next cycle.
    - Lookups during INIT do not use the port. The result is returned next cycle as pred_counter = INIT_VAL.
    - Updates are enqueued normally during INIT.
  - IDLE: if FIFO is non-empty and no lookup_valid this cycle, issue a read of the head index and go to UPD_RD_WAIT. Otherwise stay.
  - UPD_RD_WAIT (one cycle): tbl_rdata is valid. Latch wr_val = saturating counter step of tbl_rdata:
    - taken: increment, saturating at 11.
    - not-taken: decrement, saturating at 00.
    - Go to UPD_WR.
  - UPD_WR:
    - If no lookup_valid: write wr_val to the head index, pop the FIFO, go to IDLE.
    - If lookup_valid: the lookup gets the port; stay in UPD_WR holding wr_val.
  - A lookup in the IDLE→read-issue cycle preempts the read; the FSM stays in IDLE.
- Lookup latency:
  - lookup_valid in cycle N → tbl read in N, pred_valid/pred_counter in N+1.
  - Back-to-back lookups are sustained at 1 per cycle.
  - pred_valid is low in any cycle not following a lookup.
  - pred_counter/prediction hold their last value while pred_valid is low.
- Bypass: if a lookup index equals the head index while the FSM is in UPD_WR, or while in UPD_RD_WAIT (bypass value = the wr_val being computed), pred_counter = wr_val, not the stale tbl_rdata.
- Lookups do not search the rest of the FIFO; entries behind the head may return stale values (accepted).
- FIFO:
  - Enqueue on upd_valid && upd_ready. upd_ready is computed from the registered count; no same-cycle full-slot reuse.
  - upd_valid while full → entry dropped, upd_drop pulses the next cycle.
  - Updates are applied strictly in order. Two updates to the same index are applied sequentially; the second RMW reads the first's written value.
- Port rules: exactly one access per cycle maximum; tbl_en is 0 when idle.

Test Plan:
1. Release rst_n with IDX_W=6 → 64 consecutive writes, tbl_addr 0..63, tbl_wdata=01; init_done rises the cycle after the addr-63 write; no other port activity.
2. After init, three upd_taken=1 updates to upd_addr 0x4 with no lookups → table[1] goes 01→10→11→11. A subsequent lookup_addr=0x4, offset=0 → pred_valid with pred_counter=11, prediction=1.
3. Then three upd_taken=0 updates to 0x4 → 11→10→01→00. Lookup_addr=0x0, offset=0x4 → pred_counter=00, prediction=0.
4. One update queued, lookup_valid held high 10 cycles → no tbl_we asserted during the 10 cycles; the write completes within 3 cycles of lookup_valid falling; busy falls after the write.
5. Lookup held high, 5 back-to-back upd_valid → upd_ready low after the 4th; 5th dropped with a single upd_drop pulse; after lookups stop, exactly 4 writes occur in order.
6. Update taken to 0x8 (table 01) stalled in UPD_WR by a lookup to 0x8 → pred_counter=10 (bypass). Then assert rst_n low mid-RMW → FIFO empty, INIT restarts at addr 0.
